// File: rtl/and4_seq_pkg.sv
// Shared types and constants for the four-input AND gate sweep sequencer.
package and4_seq_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDrive  = 3'd1,
    StSettle = 3'd2,
    StSample = 3'd3,
    StDone   = 3'd4
  } seq_state_e;

  localparam logic [3:0] VEC_LAST = 4'hF;
  localparam logic [4:0] ERR_MAX  = 5'd31;

  function automatic logic golden_and4(input logic [3:0] vec);
    return &vec;
  endfunction

endpackage

// File: rtl/and4_settle_timer.sv
// Loadable down-counter that times the settle window after each new vector.
module and4_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_zero
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(SETTLE_CYCLES - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_load) begin
      w_cnt_d = LoadVal;
    end else if (i_en && (r_cnt != '0)) begin
      w_cnt_d = r_cnt - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/and4_vec_sequencer.sv
// Sweeps all 16 input vectors through a four-input AND gate and counts mismatches.
// Optional first-failure capture is enabled by defining AND4_FIRST_FAIL_CAPTURE_EN.
module and4_vec_sequencer
  import and4_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned VEC_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_out,
  output logic             a1,
  output logic             b1,
  output logic             a2,
  output logic             b2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [4:0]       err_count
`ifdef AND4_FIRST_FAIL_CAPTURE_EN
  ,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_vld
`endif
);

  seq_state_e       r_state, w_state_d;
  logic [VEC_W-1:0] r_vec, w_vec_d;
  logic [4:0]       r_err, w_err_d;
  logic             w_timer_load, w_timer_en, w_timer_zero;
  logic             w_mismatch, w_start_sweep;
`ifdef AND4_FIRST_FAIL_CAPTURE_EN
  logic [VEC_W-1:0] r_ff_vec, w_ff_vec_d;
  logic             r_ff_vld, w_ff_vld_d;
`endif

  and4_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(w_timer_load),
    .i_en  (w_timer_en),
    .o_zero(w_timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone: if (start) w_state_d = StDrive;
      StDrive:        w_state_d = StSettle;
      StSettle:       if (w_timer_zero) w_state_d = StSample;
      StSample:       w_state_d = (r_vec == VEC_LAST) ? StDone : StDrive;
      default:        w_state_d = StIdle;
    endcase
  end

  always_comb begin
    busy         = (r_state == StDrive) || (r_state == StSettle) || (r_state == StSample);
    done         = (r_state == StDone);
    pass         = (r_state == StDone) && (r_err == '0);
    w_timer_load = (r_state == StDrive);
    w_timer_en   = (r_state == StSettle);
  end

  // Match is tested in the if-branch so an unknown dut_out lands in the mismatch branch.
  always_comb begin
    w_mismatch = 1'b1;
    if (dut_out == golden_and4(r_vec)) begin
      w_mismatch = 1'b0;
    end
  end

  assign w_start_sweep = start && ((r_state == StIdle) || (r_state == StDone));

  always_comb begin
    w_vec_d    = r_vec;
    w_err_d    = r_err;
`ifdef AND4_FIRST_FAIL_CAPTURE_EN
    w_ff_vec_d = r_ff_vec;
    w_ff_vld_d = r_ff_vld;
`endif
    if (w_start_sweep) begin
      w_vec_d    = '0;
      w_err_d    = '0;
`ifdef AND4_FIRST_FAIL_CAPTURE_EN
      w_ff_vec_d = '0;
      w_ff_vld_d = 1'b0;
`endif
    end else if (r_state == StSample) begin
      if (w_mismatch) begin
        if (r_err != ERR_MAX) w_err_d = r_err + 5'd1;
`ifdef AND4_FIRST_FAIL_CAPTURE_EN
        if (!r_ff_vld) begin
          w_ff_vec_d = r_vec;
          w_ff_vld_d = 1'b1;
        end
`endif
      end
      if (r_vec != VEC_LAST) w_vec_d = r_vec + VEC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec    <= '0;
      r_err    <= '0;
`ifdef AND4_FIRST_FAIL_CAPTURE_EN
      r_ff_vec <= '0;
      r_ff_vld <= 1'b0;
`endif
    end else begin
      r_vec    <= w_vec_d;
      r_err    <= w_err_d;
`ifdef AND4_FIRST_FAIL_CAPTURE_EN
      r_ff_vec <= w_ff_vec_d;
      r_ff_vld <= w_ff_vld_d;
`endif
    end
  end

  assign a1        = r_vec[3];
  assign b1        = r_vec[2];
  assign a2        = r_vec[1];
  assign b2        = r_vec[0];
  assign err_count = r_err;
`ifdef AND4_FIRST_FAIL_CAPTURE_EN
  assign first_fail_vec = r_ff_vec;
  assign first_fail_vld = r_ff_vld;
`endif

endmodule

// File: tb/tb_and4_vec_sequencer.sv
// Self-checking bench: table of gate behaviours (fixed and random response masks),
// plus hand-written sequences for restart, start-while-busy and mid-sweep reset.
module tb_and4_vec_sequencer;

  localparam int unsigned Settle = 2;
  localparam int unsigned Period = Settle + 2;
  localparam int unsigned Sweep  = 16 * Period;
  localparam int unsigned Bound  = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        dut_out;
  logic        a1, b1, a2, b2, busy, done, pass;
  logic [4:0]  err_count;
  logic [15:0] r_mask = 16'h8000;
  logic [3:0]  vec;
`ifdef AND4_FIRST_FAIL_CAPTURE_EN
  logic [3:0]  first_fail_vec;
  logic        first_fail_vld;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign vec = {a1, b1, a2, b2};
  // The emulated gate answers with bit <vec> of the response mask; 16'h8000 is a true AND.
  assign dut_out = r_mask[vec];

  and4_vec_sequencer #(
    .SETTLE_CYCLES(Settle),
    .VEC_W        (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .dut_out       (dut_out),
    .a1            (a1),
    .b1            (b1),
    .a2            (a2),
    .b2            (b2),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count)
`ifdef AND4_FIRST_FAIL_CAPTURE_EN
    ,
    .first_fail_vec(first_fail_vec),
    .first_fail_vld(first_fail_vld)
`endif
  );

  typedef struct {
    string       name;
    logic [15:0] mask;
    int          exp_err;
    logic        exp_pass;
    int          exp_ffv;
    logic        exp_ffvld;
  } sweep_t;

  sweep_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: a vector mismatches when the gate's answer differs from "all four inputs high".
  function automatic int model_err(input logic [15:0] mask);
    int e;
    e = 0;
    for (int v = 0; v < 16; v++) if (mask[v] != (v == 15)) e++;
    return (e > 31) ? 31 : e;
  endfunction

  function automatic int model_first(input logic [15:0] mask);
    for (int v = 0; v < 16; v++) if (mask[v] != (v == 15)) return v;
    return 0;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_drive_entry(input string name);
    check({name, "_drive_vec"}, 32'(vec), 32'd0);
    check({name, "_drive_err"}, 32'(err_count), 32'd0);
    check({name, "_drive_busy"}, 32'({busy, done, pass}), 32'b100);
  endtask

  task automatic wait_done(inout int n);
    while (!done && n < Bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_result(input sweep_t s);
    check({s.name, "_err"}, 32'(err_count), 32'(s.exp_err));
    check({s.name, "_pass"}, 32'({done, pass}), 32'({1'b1, s.exp_pass}));
`ifdef AND4_FIRST_FAIL_CAPTURE_EN
    check({s.name, "_ffvld"}, 32'(first_fail_vld), 32'(s.exp_ffvld));
    check({s.name, "_ffvec"}, 32'(first_fail_vec), 32'(s.exp_ffv));
`endif
  endtask

  task automatic run_sweep(input sweep_t s);
    int n;
    r_mask = s.mask;
    pulse_start();
    check_drive_entry(s.name);
    n = 0;
    wait_done(n);
    check({s.name, "_cycles"}, 32'(n), 32'(Sweep));
    check_result(s);
  endtask

  task automatic wait_vec(input logic [3:0] target, input string name);
    int n;
    n = 0;
    while (vec != target && n < Bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= Bound) check({name, "_wait_vec"}, 32'(vec), 32'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sweep_t s;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", 32'({vec, busy, done, pass, err_count}), 32'd0);
`ifdef AND4_FIRST_FAIL_CAPTURE_EN
      check("idle_ff", 32'({first_fail_vld, first_fail_vec}), 32'd0);
`endif
    end

    // Correct gate, traced cycle by cycle from the first DRIVE
    r_mask = 16'h8000;
    pulse_start();
    for (int k = 0; k < int'(Sweep); k++) begin
      check("trace_vec", 32'(vec), 32'(k / Period));
      check("trace_busy", 32'({busy, done}), 32'b10);
      @(negedge clk);
    end
    check("trace_done", 32'({busy, done, pass, err_count}), 32'({1'b0, 1'b1, 1'b1, 5'd0}));

    // Table of gate behaviours: fixed expectations, then random response masks
    tbl.push_back('{"correct", 16'h8000, 0, 1'b1, 0, 1'b0});
    tbl.push_back('{"stuck0", 16'h0000, 1, 1'b0, 15, 1'b1});
    tbl.push_back('{"stuck1", 16'hFFFF, 15, 1'b0, 0, 1'b1});
    for (int i = 0; i < 6; i++) begin
      s.name      = $sformatf("rand%0d", i);
      s.mask      = 16'($urandom);
      s.exp_err   = model_err(s.mask);
      s.exp_pass  = (s.exp_err == 0);
      s.exp_ffv   = model_first(s.mask);
      s.exp_ffvld = (s.exp_err != 0);
      tbl.push_back(s);
    end
    for (int i = 0; i < tbl.size(); i++) run_sweep(tbl[i]);

    // Start while busy is ignored, then a restart from DONE clears the count
    r_mask = 16'hFFFF;
    pulse_start();
    n = 0;
    while (vec != 4'd5 && n < Bound) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b0;
    wait_done(n);
    check("busy_start_cycles", 32'(n), 32'(Sweep));
    check("busy_start_err", 32'(err_count), 32'(model_err(16'hFFFF)));
    r_mask = 16'h8000;
    pulse_start();
    check_drive_entry("restart");
    n = 0;
    wait_done(n);
    check("restart_cycles", 32'(n), 32'(Sweep));
    check("restart_pass", 32'({pass, err_count}), 32'({1'b1, 5'd0}));

    // Asynchronous reset at vector 9, between clock edges
    r_mask = 16'hFFFF;
    pulse_start();
    wait_vec(4'd9, "midrst");
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({vec, busy, done, pass, err_count}), 32'd0);
`ifdef AND4_FIRST_FAIL_CAPTURE_EN
    check("midrst_ff", 32'({first_fail_vld, first_fail_vec}), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'({vec, busy, done, err_count}), 32'd0);
    run_sweep('{"post_rst", 16'h8000, 0, 1'b1, 0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/and4_vec_sequencer.md
Name: and4_vec_sequencer

Overview:
- Synthesizable, self-checking stimulus sequencer placed directly upstream and downstream of the four-input AND gate block.
- Drives all 16 input combinations onto a1/b1/a2/b2 in ascending order and samples the gate's out.
- Compares each sample against the golden AND of the current vector and accumulates a mismatch count.
- Reports done/pass for board-level bring-up (LEDs) or for a top-level bench.

Parameters:
- SETTLE_CYCLES, 2, cycles held in SETTLE after each new vector before sampling (legal range 1..15).
- VEC_W, 4, vector width; fixed at 4, one bit per gate input.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse that begins a sweep; sampled only in IDLE or DONE
- dut_out  input  1  output of the AND gate under test
- a1  output  1  gate input, equals vec[3]
- b1  output  1  gate input, equals vec[2]
- a2  output  1  gate input, equals vec[1]
- b2  output  1  gate input, equals vec[0]
- busy  output  1  high in DRIVE, SETTLE and SAMPLE
- done  output  1  high only in DONE
- pass  output  1  high only in DONE when err_count==0
- err_count  output  5  number of mismatching vectors in the last or current sweep
- first_fail_vec  output  4  present only with the optional feature
- first_fail_vld  output  1  present only with the optional feature

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low on rst_n, with release synchronous to clk by the integrating design.
- Reset values:
  - state=IDLE, vec=0, settle counter=0, err_count=0.
  - a1/b1/a2/b2 = 0.
  - busy=0, done=0, pass=0.
  - first_fail_vec=0, first_fail_vld=0.
- All outputs are registered or decoded from registered state; no combinational path from dut_out to any output.
- IDLE:
  - start=1 → DRIVE; vec←0, err_count←0, first_fail cleared.
  - Otherwise remain in IDLE.
- DRIVE: one cycle. a1..b2 already reflect vec. Settle counter ←SETTLE_CYCLES-1. Next state SETTLE.
- SETTLE:
  - Counter decrements each cycle.
  - counter==0 → SAMPLE.
  - Occupies exactly SETTLE_CYCLES cycles.
- SAMPLE: one cycle.
  - expected = (vec==4'hF).
  - If dut_out != expected: err_count increments, saturating at 31.
  - vec==15 → DONE. Otherwise vec←vec+1 → DRIVE.
- Per-vector period: SETTLE_CYCLES+2 cycles.
- Full sweep: 16×(SETTLE_CYCLES+2) cycles. With the default that is 64 cycles from the first DRIVE to the first DONE cycle.
- DONE:
  - done=1; pass=(err_count==0).
  - vec holds 15; err_count holds.
  - Remains until start or reset.
  - start in DONE restarts exactly as from IDLE: done/pass drop the next cycle, busy rises.
- start while busy is ignored; no restart and no effect on counts.
- dut_out=X/Z counts as a mismatch in simulation only; synthesis treats it as ordinary 1-bit compare.
- rst_n low mid-sweep: immediate return to reset values; a sweep never resumes.
- vec does not wrap. The SAMPLE at 15 always exits to DONE.

Optional Feature:
- Macro: AND4_FIRST_FAIL_CAPTURE_EN.
- Defined:
  - On the first mismatching SAMPLE of a sweep: first_fail_vec←vec, first_fail_vld←1.
  - Later mismatches do not overwrite.
  - Both are cleared on sweep start and on reset.
- Undefined:
  - Ports and registers are absent.
  - All other behaviour is identical.

Decomposition:
- Package and4_seq_pkg holds:
  - state enum: IDLE, DRIVE, SETTLE, SAMPLE, DONE (3-bit logic).
  - VEC_LAST=4'hF.
  - ERR_MAX=5'd31.
  - a function golden_and4(vec) returning &vec.
- One natural sub-module, and4_settle_timer: loadable down-counter with load, en and zero flag, sized by SETTLE_CYCLES.
- The top-level FSM instantiates and4_settle_timer.

Test Plan:
- Reset/idle:
  - Hold rst_n=0 for 3 cycles, release, no start.
  - Required: all outputs 0, busy=0 for 20 cycles.
- Correct gate:
  - Connect the real four-input AND and pulse start.
  - Required:
    - a1..b2 step 0000→1111, each vector held 4 cycles.
    - done=1 exactly 64 cycles after the first DRIVE.
    - pass=1, err_count=0.
- Stuck-at-0 gate:
  - Tie dut_out=0 and run a sweep.
  - Required: err_count=1, pass=0; with the feature, first_fail_vec=4'hF and first_fail_vld=1.
- Stuck-at-1 gate:
  - Tie dut_out=1 and run a sweep.
  - Required: err_count=15, pass=0; with the feature, first_fail_vec=4'h0.
- Start during busy, then restart:
  - Pulse start at vector 5, then again after done.
  - Required:
    - The first extra pulse is ignored; the sweep completes normally.
    - The second pulse clears err_count and restarts at vec=0.
- Reset mid-sweep:
  - Drop rst_n asynchronously at vector 9, between clock edges.
  - Required: outputs go to 0 immediately, without waiting for a clock edge; a later start begins at vec=0 with err_count=0.
